// File: rtl/rf_subfile_router.sv
// Routes single host RF accesses to one of NUM_SUB sub-register-files and returns the
// completion status and read data. Stalled accesses end as invalid through a watchdog.
module rf_subfile_router #(
  parameter int ADDR_W  = 12,
  parameter int SEL_W   = 2,
  parameter int NUM_SUB = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  localparam int SUB_AW = ADDR_W - SEL_W - 3
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [ADDR_W-4:0]         address,
  input  logic                      read_en,
  input  logic                      write_en,
  input  logic [DATA_W-1:0]         write_data,
  output logic [DATA_W-1:0]         read_data,
  output logic                      access_complete,
  output logic                      invalid_address,
  output logic                      busy,
  output logic [SUB_AW-1:0]         sub_address,
  output logic [DATA_W-1:0]         sub_write_data,
  output logic [NUM_SUB-1:0]        sub_read_en,
  output logic [NUM_SUB-1:0]        sub_write_en,
  input  logic [NUM_SUB*DATA_W-1:0] sub_read_data,
  input  logic [NUM_SUB-1:0]        sub_access_complete,
  input  logic [NUM_SUB-1:0]        sub_invalid_address
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic                is_read_q, is_read_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                ac_q, ac_d;
  logic                inv_q, inv_d;
  logic                busy_q, busy_d;
  logic [SUB_AW-1:0]   sub_address_q, sub_address_d;
  logic [DATA_W-1:0]   sub_write_data_q, sub_write_data_d;
  logic [NUM_SUB-1:0]  sub_read_en_q, sub_read_en_d;
  logic [NUM_SUB-1:0]  sub_write_en_q, sub_write_en_d;

  logic [DATA_W-1:0]   sub_rd_arr [NUM_SUB];
  logic [SEL_W-1:0]    sel_in;
  logic                sel_mapped;
  logic [NUM_SUB-1:0]  port_onehot;
  logic                pend_done;
  logic                pend_inv;
  logic [DATA_W-1:0]   pend_data;

  for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_unpack
    assign sub_rd_arr[gi] = sub_read_data[gi*DATA_W +: DATA_W];
  end

  assign sel_in     = address[ADDR_W-4 -: SEL_W];
  assign sel_mapped = (32'(sel_in) < NUM_SUB);

  // Decode the incoming select and mux the status of the latched (pending) port only.
  always_comb begin
    port_onehot = '0;
    pend_done   = 1'b0;
    pend_inv    = 1'b0;
    pend_data   = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (sel_in == SEL_W'(i)) port_onehot[i] = 1'b1;
      if (sel_q == SEL_W'(i)) begin
        pend_done = sub_access_complete[i];
        pend_inv  = sub_invalid_address[i];
        pend_data = sub_rd_arr[i];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    wd_d             = wd_q;
    is_read_d        = is_read_q;
    read_data_d      = read_data_q;
    ac_d             = 1'b0;
    inv_d            = 1'b0;
    sub_address_d    = sub_address_q;
    sub_write_data_d = sub_write_data_q;
    sub_read_en_d    = '0;
    sub_write_en_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (read_en || write_en) begin
          if ((read_en && write_en) || !sel_mapped) begin
            state_d = ST_RESP;
            ac_d    = 1'b1;
            inv_d   = 1'b1;
          end else begin
            state_d          = ST_WAIT;
            sel_d            = sel_in;
            wd_d             = '0;
            is_read_d        = read_en;
            sub_address_d    = address[SUB_AW-1:0];
            sub_write_data_d = write_data;
            sub_read_en_d    = read_en  ? port_onehot : '0;
            sub_write_en_d   = write_en ? port_onehot : '0;
          end
        end
      end
      ST_WAIT: begin
        // A completion arriving on the timeout cycle takes priority over the watchdog.
        if (pend_done) begin
          state_d = ST_IDLE;
          ac_d    = 1'b1;
          inv_d   = pend_inv;
          if (is_read_q) read_data_d = pend_data;
        end else if ((TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT))) begin
          state_d = ST_IDLE;
          ac_d    = 1'b1;
          inv_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q          <= ST_IDLE;
      sel_q            <= '0;
      wd_q             <= '0;
      is_read_q        <= 1'b0;
      read_data_q      <= '0;
      ac_q             <= 1'b0;
      inv_q            <= 1'b0;
      busy_q           <= 1'b0;
      sub_address_q    <= '0;
      sub_write_data_q <= '0;
      sub_read_en_q    <= '0;
      sub_write_en_q   <= '0;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      wd_q             <= wd_d;
      is_read_q        <= is_read_d;
      read_data_q      <= read_data_d;
      ac_q             <= ac_d;
      inv_q            <= inv_d;
      busy_q           <= busy_d;
      sub_address_q    <= sub_address_d;
      sub_write_data_q <= sub_write_data_d;
      sub_read_en_q    <= sub_read_en_d;
      sub_write_en_q   <= sub_write_en_d;
    end
  end

  assign read_data       = read_data_q;
  assign access_complete = ac_q;
  assign invalid_address = inv_q;
  assign busy            = busy_q;
  assign sub_address     = sub_address_q;
  assign sub_write_data  = sub_write_data_q;
  assign sub_read_en     = sub_read_en_q;
  assign sub_write_en    = sub_write_en_q;

endmodule

// File: tb/tb_rf_subfile_router.sv
// Directed bench for rf_subfile_router: three sub ports, watchdog TIMEOUT=4.
module tb_rf_subfile_router;

  localparam int ADDR_W  = 12;
  localparam int SEL_W   = 2;
  localparam int NUM_SUB = 3;
  localparam int DATA_W  = 32;
  localparam int SUB_AW  = ADDR_W - SEL_W - 3;

  logic                      clk = 1'b0;
  logic                      res;
  logic [ADDR_W-4:0]         address;
  logic                      read_en;
  logic                      write_en;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         read_data;
  logic                      access_complete;
  logic                      invalid_address;
  logic                      busy;
  logic [SUB_AW-1:0]         sub_address;
  logic [DATA_W-1:0]         sub_write_data;
  logic [NUM_SUB-1:0]        sub_read_en;
  logic [NUM_SUB-1:0]        sub_write_en;
  logic [NUM_SUB*DATA_W-1:0] sub_read_data;
  logic [NUM_SUB-1:0]        sub_access_complete;
  logic [NUM_SUB-1:0]        sub_invalid_address;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_subfile_router #(
    .ADDR_W(ADDR_W), .SEL_W(SEL_W), .NUM_SUB(NUM_SUB), .DATA_W(DATA_W),
    .TIMEOUT(4), .TO_W(8)
  ) dut (
    .clk(clk), .res(res), .address(address), .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(read_data), .access_complete(access_complete),
    .invalid_address(invalid_address), .busy(busy), .sub_address(sub_address),
    .sub_write_data(sub_write_data), .sub_read_en(sub_read_en), .sub_write_en(sub_write_en),
    .sub_read_data(sub_read_data), .sub_access_complete(sub_access_complete),
    .sub_invalid_address(sub_invalid_address)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic any_out;
  assign any_out = |{read_data, access_complete, invalid_address, busy, sub_address,
                     sub_write_data, sub_read_en, sub_write_en};

  initial begin
    res = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
    sub_read_data = '0; sub_access_complete = '0; sub_invalid_address = '0;
    tick(); tick();
    check("rst_outputs_zero", 64'(any_out), 64'd0);
    res = 1'b0;
    tick();

    // Read port 1, sub completes in the strobe cycle.
    address = 9'h080; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("t1_rd_strobe", 64'(sub_read_en), 64'b010);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_no_early_ac", 64'(access_complete), 64'd0);
    sub_read_data[1*DATA_W +: DATA_W] = 32'hCAFE0001;
    sub_access_complete = 3'b010;
    tick();
    sub_access_complete = '0;
    check("t1_ac", 64'(access_complete), 64'd1);
    check("t1_inv", 64'(invalid_address), 64'd0);
    check("t1_rdata", 64'(read_data), 64'hCAFE0001);
    check("t1_strobe_gone", 64'(sub_read_en), 64'd0);
    check("t1_not_busy", 64'(busy), 64'd0);
    tick();
    check("t1_ac_pulse", 64'(access_complete), 64'd0);

    // Write port 2, completion arrives two cycles after the strobe.
    address = 9'h105; write_en = 1'b1; write_data = 32'h12345678;
    tick();
    write_en = 1'b0; write_data = '0;
    check("t2_wr_strobe", 64'(sub_write_en), 64'b100);
    check("t2_wdata", 64'(sub_write_data), 64'h12345678);
    check("t2_saddr", 64'(sub_address), 64'h05);
    check("t2_no_rd_strobe", 64'(sub_read_en), 64'd0);
    tick();
    check("t2_strobe_1cyc", 64'(sub_write_en), 64'd0);
    tick();
    check("t2_wait_no_ac", 64'(access_complete), 64'd0);
    sub_access_complete = 3'b100;
    tick();
    sub_access_complete = '0;
    check("t2_ac", 64'(access_complete), 64'd1);
    check("t2_inv", 64'(invalid_address), 64'd0);
    check("t2_rdata_held", 64'(read_data), 64'hCAFE0001);
    check("t2_saddr_hold", 64'(sub_address), 64'h05);

    // Unmapped select 3.
    address = 9'h180; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("t3_ac", 64'(access_complete), 64'd1);
    check("t3_inv", 64'(invalid_address), 64'd1);
    check("t3_no_strobe", 64'({sub_read_en, sub_write_en}), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    tick();
    check("t3_ac_off", 64'({access_complete, invalid_address, busy}), 64'd0);

    // Port 0 never completes: watchdog fires 6 cycles after the request.
    address = 9'h000; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t4_wait_c%0d", k), 64'(access_complete), 64'd0);
      tick();
    end
    check("t4_to_ac", 64'(access_complete), 64'd1);
    check("t4_to_inv", 64'(invalid_address), 64'd1);
    check("t4_to_rdata_held", 64'(read_data), 64'hCAFE0001);
    tick();
    check("t4_ac_off", 64'(access_complete), 64'd0);

    // Completion on the timeout cycle beats the watchdog.
    address = 9'h000; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    tick(); tick(); tick(); tick();
    sub_read_data[0 +: DATA_W] = 32'hBEEF0000;
    sub_access_complete = 3'b001;
    tick();
    sub_access_complete = '0;
    check("t4b_ac", 64'(access_complete), 64'd1);
    check("t4b_inv", 64'(invalid_address), 64'd0);
    check("t4b_rdata", 64'(read_data), 64'hBEEF0000);

    // Request while busy and a foreign port completion are both ignored.
    tick();
    address = 9'h000; read_en = 1'b1;
    tick();
    address = 9'h080;
    sub_access_complete = 3'b100; sub_invalid_address = 3'b100;
    tick();
    read_en = 1'b0; sub_access_complete = '0; sub_invalid_address = '0;
    check("t5_foreign_ignored", 64'(access_complete), 64'd0);
    check("t5_busy_req_dropped", 64'(sub_read_en), 64'd0);
    sub_read_data[0 +: DATA_W] = 32'h5555AAAA;
    sub_access_complete = 3'b001; sub_invalid_address = 3'b001;
    tick();
    sub_access_complete = '0; sub_invalid_address = '0;
    check("t5_ac", 64'(access_complete), 64'd1);
    check("t5_inv_pass", 64'(invalid_address), 64'd1);
    check("t5_rdata", 64'(read_data), 64'h5555AAAA);
    tick();
    check("t5_single_ac", 64'(access_complete), 64'd0);

    // Reset mid-access, then a late sub completion.
    address = 9'h080; read_en = 1'b1;
    tick();
    read_en = 1'b0; res = 1'b1;
    tick();
    res = 1'b0;
    sub_read_data[1*DATA_W +: DATA_W] = 32'h0BADF00D;
    sub_access_complete = 3'b010;
    tick();
    sub_access_complete = '0;
    check("t6_late_ignored", 64'(any_out), 64'd0);
    address = 9'h080; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    sub_access_complete = 3'b010;
    tick();
    sub_access_complete = '0;
    check("t6_ac", 64'(access_complete), 64'd1);
    check("t6_rdata", 64'(read_data), 64'h0BADF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
